// File: rtl/mute_gate_ctrl.sv
// Power-up mute and BCK-loss gate for the I2S lines feeding the TDA1540 path.
// Lines are held at IDLE_LEVEL until BCK has been stable for the resume window.
module mute_gate_ctrl #(
    parameter int unsigned    CLK_HZ      = 50000000,
    parameter int unsigned    STARTUP_S   = 30,
    parameter int unsigned    RESUME_MS   = 500,
    parameter int unsigned    LOSS_CYCLES = 64,
    parameter int unsigned    NCH         = 3,
    parameter logic [NCH-1:0] IDLE_LEVEL  = '0
) (
    input  logic           in_clk,
    input  logic           in_rst_n,
    input  logic [NCH-1:0] in_ch,
    input  logic           in_mute_req,
    output logic [NCH-1:0] out_ch,
    output logic           out_mute_led,
    output logic [2:0]     out_state,
    output logic [7:0]     out_loss_cnt
);

    localparam int unsigned PRESC_DIV     = CLK_HZ / 1000;
    localparam int unsigned PW            = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int unsigned STARTUP_TICKS = STARTUP_S * 1000;
    localparam int unsigned MS_MAX        = (STARTUP_TICKS > RESUME_MS) ? STARTUP_TICKS : RESUME_MS;
    localparam int unsigned MW            = $clog2(MS_MAX + 1);
    localparam int unsigned GW            = $clog2(LOSS_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESC_DIV - 1);
    localparam logic [MW-1:0] STARTUP_LAST = MW'(STARTUP_TICKS - 1);
    localparam logic [MW-1:0] RESUME_LAST  = MW'(RESUME_MS - 1);
    localparam logic [GW-1:0] GAP_MAX      = GW'(LOSS_CYCLES);

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_RESUME  = 3'd1,
        ST_ARMING  = 3'd2,
        ST_UNMUTED = 3'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic [MW-1:0] ms_cnt;
    logic [MW-1:0] ms_next;
    logic [7:0]    loss_cnt;
    logic [7:0]    loss_next;
    logic          enable;
    logic          enable_next;
    logic          mute_led;
    logic          s1;
    logic          s2;
    logic          s3;
    logic          bck_edge;
    logic [GW-1:0] gap;
    logic          sck_ok;
    logic          sck_ok_d;
    logic          loss_rise;

    // Free-running millisecond prescaler.
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // BCK synchroniser and activity monitor.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_ch[0];
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign bck_edge = s2 ^ s3;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            gap <= '0;
        end else if (bck_edge) begin
            gap <= '0;
        end else if (gap != GAP_MAX) begin
            gap <= gap + GW'(1);
        end
    end

    assign sck_ok = (gap < GAP_MAX);

    // Held high out of reset so the first cycle can never look like a fresh loss.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sck_ok_d <= 1'b1;
        end else begin
            sck_ok_d <= sck_ok;
        end
    end

    assign loss_rise = sck_ok_d & ~sck_ok;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= ST_STARTUP;
            ms_cnt   <= '0;
            loss_cnt <= '0;
            enable   <= 1'b0;
            mute_led <= 1'b1;
        end else begin
            state    <= state_next;
            ms_cnt   <= ms_next;
            loss_cnt <= loss_next;
            enable   <= enable_next;
            mute_led <= ~enable_next;
        end
    end

    always_comb begin
        state_next = state;
        ms_next    = ms_cnt;
        loss_next  = loss_cnt;
        case (state)
            ST_STARTUP: begin
                if (tick) begin
                    if (ms_cnt == STARTUP_LAST) begin
                        state_next = ST_RESUME;
                        ms_next    = '0;
                    end else begin
                        ms_next = ms_cnt + MW'(1);
                    end
                end
            end
            ST_RESUME: begin
                if (!sck_ok || in_mute_req) begin
                    ms_next = '0;
                end else if (tick) begin
                    if (ms_cnt == RESUME_LAST) begin
                        state_next = ST_ARMING;
                        ms_next    = '0;
                    end else begin
                        ms_next = ms_cnt + MW'(1);
                    end
                end
            end
            ST_ARMING: begin
                // Open the gate only while BCK is low so the first pulse is whole.
                if (!sck_ok || in_mute_req) begin
                    state_next = ST_RESUME;
                    ms_next    = '0;
                end else if (!s2) begin
                    state_next = ST_UNMUTED;
                end
            end
            ST_UNMUTED: begin
                if (!sck_ok || in_mute_req) begin
                    state_next = ST_RESUME;
                    ms_next    = '0;
                end
                if (loss_rise && (loss_cnt != 8'hFF)) begin
                    loss_next = loss_cnt + 8'd1;
                end
            end
            default: begin
                state_next = ST_STARTUP;
                ms_next    = '0;
            end
        endcase
        enable_next = (state_next == ST_UNMUTED);
    end

    assign out_ch       = enable ? in_ch : IDLE_LEVEL;
    assign out_mute_led = mute_led;
    assign out_state    = state;
    assign out_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_mute_gate_ctrl.sv
// Directed bench for mute_gate_ctrl: startup delay, resume window, loss and
// mute-request handling, async reset and loss-counter saturation.
module tb_mute_gate_ctrl;

    localparam logic [2:0] IDLE       = 3'b010;
    localparam int         LOSS_LIM   = 8;
    localparam int         BOOT_MS    = 2000;
    localparam int         WINDOW_MS  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_ch = 3'b000;
    logic       mute_req = 1'b0;
    logic [2:0] out_ch;
    logic       led;
    logic [2:0] out_state;
    logic [7:0] loss;

    int total = 0;
    int bad = 0;

    logic bck = 1'b0;
    logic bck_run = 1'b0;
    int   ph = 0;
    int   cyc = 0;

    mute_gate_ctrl #(
        .CLK_HZ(1000),
        .STARTUP_S(2),
        .RESUME_MS(5),
        .LOSS_CYCLES(8),
        .NCH(3),
        .IDLE_LEVEL(3'b010)
    ) dut (
        .in_clk(clk),
        .in_rst_n(rst_n),
        .in_ch(in_ch),
        .in_mute_req(mute_req),
        .out_ch(out_ch),
        .out_mute_led(led),
        .out_state(out_state),
        .out_loss_cnt(loss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bck_run) begin
                ph++;
                if (ph == 3) begin
                    ph = 0;
                    bck = ~bck;
                end
            end
            in_ch = {cyc[3:2], bck};
        end
    endtask

    task automatic wait_state(input logic [2:0] code, input int max_cycles, input string name);
        int n;
        n = 0;
        while ((out_state !== code) && (n < max_cycles)) begin
            step(1);
            n++;
        end
        total++;
        if (out_state !== code) begin
            bad++;
            $display("FAIL %s: state=%0d expected %0d within %0d cycles", name, out_state, code, max_cycles);
        end
    endtask

    // Behavioural model: modes 0 boot, 1 waiting for stable BCK, 2 waiting for
    // BCK low, 3 passing audio. Every clock is one millisecond here.
    bit m_line[$];
    int m_quiet;
    int m_mode;
    int m_elapsed;
    int m_streak;
    int m_losses;

    task automatic model_reset();
        m_line.delete();
        repeat (3) m_line.push_back(1'b0);
        m_quiet   = 0;
        m_mode    = 0;
        m_elapsed = 0;
        m_streak  = 0;
        m_losses  = 0;
    endtask

    task automatic model_step();
        bit seen_lvl;
        bit prev_lvl;
        bit ok;
        bit req;
        seen_lvl = m_line[1];
        prev_lvl = m_line[2];
        ok  = (m_quiet < LOSS_LIM);
        req = mute_req;
        case (m_mode)
            0: begin
                m_elapsed++;
                if (m_elapsed == BOOT_MS) begin
                    m_mode   = 1;
                    m_streak = 0;
                end
            end
            1: begin
                if (ok && !req) m_streak++;
                else m_streak = 0;
                if (m_streak == WINDOW_MS) begin
                    m_mode   = 2;
                    m_streak = 0;
                end
            end
            2: begin
                if (!ok || req) begin
                    m_mode   = 1;
                    m_streak = 0;
                end else if (!seen_lvl) begin
                    m_mode = 3;
                end
            end
            default: begin
                if (!ok) begin
                    m_mode   = 1;
                    m_streak = 0;
                    if (m_losses < 255) m_losses++;
                end else if (req) begin
                    m_mode   = 1;
                    m_streak = 0;
                end
            end
        endcase
        if (seen_lvl != prev_lvl) m_quiet = 0;
        else if (m_quiet < LOSS_LIM) m_quiet++;
        m_line.push_front(in_ch[0]);
        void'(m_line.pop_back());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_state", out_state, m_mode);
                check("cyc_led", led, (m_mode == 3) ? 0 : 1);
                check("cyc_loss", loss, m_losses);
                check("cyc_ch", out_ch, (m_mode == 3) ? in_ch : IDLE);
            end else begin
                check("rst_state", out_state, 0);
                check("rst_led", led, 1);
                check("rst_loss", loss, 0);
                check("rst_ch", out_ch, IDLE);
            end
        end
    end

    task automatic do_reset();
        step(1);
        #2 rst_n = 1'b0;
        step(2);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // 1: release with BCK running
        bck_run = 1'b1;
        step(3);
        check("t1_rst_ch", out_ch, IDLE);
        check("t1_rst_led", led, 1);
        #2 rst_n = 1'b1;
        step(BOOT_MS - 1);
        check("t1_state_1999", out_state, 0);
        check("t1_led_1999", led, 1);
        check("t1_ch_1999", out_ch, IDLE);
        check("t1_model_1999", m_mode, 0);
        step(1);
        check("t1_state_2000", out_state, 1);
        check("t1_model_2000", m_mode, 1);
        step(WINDOW_MS);
        check("t1_state_2005", out_state, 2);
        wait_state(3'd3, 10, "t1_unmute");
        check("t1_led_on", led, 0);
        check("t1_ch_follow", out_ch, in_ch);

        // 2: BCK absent at end of startup
        bck_run = 1'b0;
        bck = 1'b0;
        do_reset();
        step(BOOT_MS);
        check("t2_state_2000", out_state, 1);
        step(3);
        check("t2_state_2003", out_state, 1);
        bck_run = 1'b1;
        step(7);
        check("t2_state_2010", out_state, 1);
        check("t2_led_2010", led, 1);
        wait_state(3'd3, 40, "t2_unmute");

        // 3: BCK stops while unmuted
        bck_run = 1'b0;
        step(14);
        check("t3_state", out_state, 1);
        check("t3_loss", loss, 1);
        check("t3_led", led, 1);
        check("t3_ch", out_ch, IDLE);
        bck_run = 1'b1;
        wait_state(3'd3, 40, "t3_reunmute");
        check("t3_led_back", led, 0);

        // 4: one-cycle mute request, then held request
        mute_req = 1'b1;
        step(1);
        mute_req = 1'b0;
        check("t4_state", out_state, 1);
        check("t4_led", led, 1);
        check("t4_loss", loss, 1);
        check("t4_ch", out_ch, IDLE);
        wait_state(3'd3, 40, "t4_reunmute");
        mute_req = 1'b1;
        step(60);
        check("t4_hold_state", out_state, 1);
        check("t4_hold_led", led, 1);
        mute_req = 1'b0;
        wait_state(3'd3, 40, "t4_release");

        // 5: async reset between clock edges while unmuted
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_ch", out_ch, IDLE);
        check("t5_async_led", led, 1);
        check("t5_async_state", out_state, 0);
        check("t5_async_loss", loss, 0);
        step(2);
        #2 rst_n = 1'b1;
        step(BOOT_MS - 1);
        check("t5_state_1999", out_state, 0);
        check("t5_led_1999", led, 1);
        step(1);
        check("t5_state_2000", out_state, 1);
        check("t5_loss", loss, 0);
        check("t5_model_loss", m_losses, 0);
        wait_state(3'd3, 40, "t5_unmute");

        // 6: 300 dropouts saturate the loss counter
        for (int k = 0; k < 300; k++) begin
            bck_run = 1'b0;
            step(14);
            bck_run = 1'b1;
            wait_state(3'd3, 40, "t6_reunmute");
        end
        check("t6_loss_sat", loss, 255);
        check("t6_model_sat", m_losses, 255);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mute_gate_ctrl.md
Name: mute_gate_ctrl

Overview:
- Parametrised successor to the fixed 30 s BCK mute.
- Holds NCH I2S-side lines (channel 0 = BCK/SCK; the rest are WS, DATA, …) at a configurable idle level for a power-up delay.
- Then unmutes only once BCK has been present continuously for a resume window.
- Re-mutes immediately on BCK loss or an external mute request, and counts loss events.
- Sits between the I2S receiver pins and the TDA1540 conversion logic.

Parameters:
- CLK_HZ, 50000000: system clock frequency; must be a multiple of 1000, ≥1000.
- STARTUP_S, 30: power-up mute time in seconds.
- RESUME_MS, 500: continuous BCK-present time required before unmute, in ms.
- LOSS_CYCLES, 64: in_clk cycles without a BCK edge that count as BCK lost; must be ≥4.
- NCH, 3: number of gated lines.
- IDLE_LEVEL, 0: NCH-bit value driven on out_ch while muted.

Ports:
- in_clk  in  1  system clock.
- in_rst_n  in  1  reset; asynchronous assert, active-low.
- in_ch  in  NCH  raw I2S lines; bit 0 = BCK.
- in_mute_req  in  1  synchronous force-mute request, level-sensitive.
- out_ch  out  NCH  gated lines.
- out_mute_led  out  1  1 = muted.
- out_state  out  3  FSM state code.
- out_loss_cnt  out  8  saturating count of BCK-loss events while unmuted.

Behaviour:
- Output gating:
  - out_ch = enable ? in_ch : IDLE_LEVEL, combinational from the registered enable; no added latency on the audio path.
  - out_mute_led = ~enable, registered.
- ms tick: prescaler counts 0..CLK_HZ/1000-1 and pulses tick for one cycle on wrap. It free-runs from reset.
- BCK monitor:
  - in_ch[0] passes through a 2-flop synchroniser (s1, s2) plus a third flop s3.
  - edge = s2 ^ s3.
  - gap counter clears on edge, otherwise increments, saturating at LOSS_CYCLES.
  - sck_ok = (gap < LOSS_CYCLES).
  - Requires in_clk ≥ 8 × BCK frequency.
- FSM, state codes as listed:
  - STARTUP (0): ms counter counts ticks; BCK and mute_req are ignored. When STARTUP_S*1000 ticks have elapsed → RESUME, clear the ms counter.
  - RESUME (1): the ms counter counts ticks while sck_ok && !in_mute_req; either condition failing clears it the same cycle. Reaching RESUME_MS ticks → ARMING.
  - ARMING (2): wait for s2 == 0 (BCK low) with sck_ok && !in_mute_req, then set enable=1 → UNMUTED. This avoids a runt first BCK pulse. Loss or mute_req → RESUME with the counter cleared.
  - UNMUTED (3): enable=1. A rising edge of (!sck_ok) → enable=0 next cycle, out_loss_cnt +1 (saturates at 255), → RESUME. in_mute_req=1 → enable=0 next cycle, → RESUME, no count. If both occur in the same cycle, the count increments once.
  - Codes 4–7 are unused; recover to STARTUP.
- Reset (async, any time including mid-unmute):
  - enable=0, so out_ch=IDLE_LEVEL immediately.
  - out_mute_led=1, state=STARTUP, all counters 0, out_loss_cnt=0, synchroniser flops 0.
  - The full STARTUP_S delay repeats after reset release.
- Widths: ms counter sized for max(STARTUP_S*1000, RESUME_MS); prescaler sized for CLK_HZ/1000; gap counter sized for LOSS_CYCLES. No wrap is permitted; all counters saturate or clear as stated.
- in_mute_req held high: the block stays in RESUME indefinitely with enable=0.

Test Plan:
Bench parameters: CLK_HZ=1000 (tick every cycle), STARTUP_S=2, RESUME_MS=5, LOSS_CYCLES=8, NCH=3, IDLE_LEVEL=3'b010; BCK toggles every 3 cycles.
1. Reset release with BCK running:
   - out_ch=3'b010, out_mute_led=1 through cycle 2000.
   - State RESUME at ~2000, ARMING at ~2005.
   - enable rises only while synchronised BCK is low; afterwards out_ch follows in_ch; LED 0.
2. BCK absent at end of STARTUP, starting at cycle 2003:
   - Remains RESUME (code 1).
   - Unmutes only ≥5 ticks after BCK edges resume.
3. Unmuted, BCK stops:
   - Within 8+3 cycles enable=0, out_ch=3'b010, out_loss_cnt=1, state=1.
   - After BCK resumes, unmutes again after 5 ms + arming.
4. Unmuted, in_mute_req pulsed for 1 cycle:
   - Mute on the next cycle, out_loss_cnt unchanged, re-unmute after the 5 ms window.
   - With mute_req held: muted indefinitely.
5. Async reset asserted mid-UNMUTED between clock edges:
   - out_ch=3'b010 and LED=1 without waiting for a clock edge.
   - After release, the full 2000-cycle STARTUP repeats; out_loss_cnt=0.
6. 300 BCK dropouts while unmuted: out_loss_cnt saturates at 255.
